// File: rtl/idct_8pt.sv
// Sequential 8-point 1-D inverse DCT: one Q15 multiply-accumulate per cycle,
// eight cycles per pixel, each pixel written to the reconstruction RAM.
module idct_8pt #(
    parameter int COEF_W = 12,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [2:0]               add,
    input  logic signed [COEF_W-1:0] data_in,
    input  logic                     start,
    input  logic [6:0]               base_add,
    output logic                     busy,
    output logic [7:0]               data_out,
    output logic [6:0]               ram_idct_add,
    output logic                     wea,
    output logic                     done
);

    // Handshake: wr and start are taken only on edges where busy=0; busy rises
    // on the accepting edge and falls on the edge that raises the final wea/done.
    typedef enum logic {IDLE, COMPUTE} state_t;

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(32'sd32768);

    state_t                   state_q, state_d;
    logic [2:0]               n_q, n_d, k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [COEF_W-1:0] coef_q [8];
    logic signed [COEF_W-1:0] coef_d [8];
    logic [6:0]               base_q, base_d;
    logic [7:0]               data_out_q, data_out_d;
    logic [6:0]               addr_q, addr_d;
    logic                     wea_q, wea_d, done_q, done_d;

    logic [4:0]               m;
    logic [16:0]              w_mag;
    logic signed [16:0]       w;
    logic signed [COEF_W+16:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, sum, rnd;
    logic [7:0]               pix;

    // Cosine ROM: angle index m = (2n+1)k mod 32, folded onto one quadrant.
    always_comb begin
        m = {1'b0, n_q, 1'b1} * {2'b00, k_q};
        case (m[3:0])
            4'd0:         w_mag = 17'd32768;
            4'd1, 4'd15:  w_mag = 17'd32138;
            4'd2, 4'd14:  w_mag = 17'd30274;
            4'd3, 4'd13:  w_mag = 17'd27246;
            4'd4, 4'd12:  w_mag = 17'd23170;
            4'd5, 4'd11:  w_mag = 17'd18205;
            4'd6, 4'd10:  w_mag = 17'd12540;
            4'd7, 4'd9:   w_mag = 17'd6393;
            default:      w_mag = 17'd0;
        endcase
        if (k_q == 3'd0)
            w = 17'sd23170;
        else if (m >= 5'd9 && m <= 5'd23)
            w = -$signed(w_mag);
        else
            w = $signed(w_mag);
    end

    always_comb begin
        prod     = coef_q[k_q] * w;
        prod_ext = $signed({{(ACC_W-COEF_W-17){prod[COEF_W+16]}}, prod});
        sum      = acc_q + prod_ext;
        rnd      = (sum + HALF) >>> 16;
        if (rnd[ACC_W-1])
            pix = 8'd0;
        else if (|rnd[ACC_W-2:8])
            pix = 8'd255;
        else
            pix = rnd[7:0];
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        acc_d      = acc_q;
        coef_d     = coef_q;
        base_d     = base_q;
        data_out_d = data_out_q;
        addr_d     = addr_q;
        wea_d      = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr)
                    coef_d[add] = data_in;
                if (start) begin
                    base_d  = base_add;
                    n_d     = 3'd0;
                    k_d     = 3'd0;
                    acc_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (k_q == 3'd7) begin
                    data_out_d = pix;
                    addr_d     = base_q + {4'b0000, n_q};
                    wea_d      = 1'b1;
                    acc_d      = '0;
                    k_d        = 3'd0;
                    n_d        = n_q + 3'd1;
                    if (n_q == 3'd7) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            base_q     <= '0;
            data_out_q <= '0;
            addr_q     <= '0;
            wea_q      <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 8; i++)
                coef_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            data_out_q <= data_out_d;
            addr_q     <= addr_d;
            wea_q      <= wea_d;
            done_q     <= done_d;
            coef_q     <= coef_d;
        end
    end

    assign busy         = (state_q == COMPUTE);
    assign data_out     = data_out_q;
    assign ram_idct_add = addr_q;
    assign wea          = wea_q;
    assign done         = done_q;

endmodule
